operand_fetch: RTL and testbench

- Operand-fetch stage sitting directly upstream of the register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file's two synchronous read ports.
- Merges the read data with bypass from the writeback port, which it snoops.
- Presents both operand values downstream over a valid/ready handshake, correct even under backpressure and back-to-back RAW hazards.

---
 rtl/operand_fetch.sv | 178 +++++++++++++++++
 tb/tb_operand_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch stage placed directly upstream of the register file. Decoded
// instructions arrive over a valid/ready handshake and enter slot A while the
// register-file reads are in flight. They then move to slot B, the output
// register, with both operands resolved. Operands are merged with the
// writeback port, which is snooped both live and one cycle delayed.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_rs1, in_rs2             source register indices
//   in_rd, in_tag              payload carried through unchanged
//   rf_rs1_addr, rf_rs2_addr   register-file read addresses (combinational)
//   rf_rs1_data, rf_rs2_data   register-file read data, one cycle after address
//   wb_addr, wb_data, wb_wren  snooped writeback port
//   flush                      synchronous kill of both slots
//   out_valid / out_ready      downstream handshake
//   out_rs1_val, out_rs2_val   resolved operands
//   out_rd, out_tag            carried payload
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned TAG_WIDTH  = 8,
    localparam int unsigned AW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rs1,
    input  logic [AW-1:0]         in_rs2,
    input  logic [AW-1:0]         in_rd,
    input  logic [TAG_WIDTH-1:0]  in_tag,

    output logic [AW-1:0]         rf_rs1_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs1_data,
    output logic [AW-1:0]         rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs2_data,

    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_wren,

    input  logic                  flush,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs1_val,
    output logic [DATA_WIDTH-1:0] out_rs2_val,
    output logic [AW-1:0]         out_rd,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    // Slot A: instruction whose register-file reads are in flight.
    logic                  a_valid;
    logic [AW-1:0]         a_rs1;
    logic [AW-1:0]         a_rs2;
    logic [AW-1:0]         a_rd;
    logic [TAG_WIDTH-1:0]  a_tag;

    // Source indices of the instruction held in slot B, for held-operand bypass.
    logic [AW-1:0]         b_rs1;
    logic [AW-1:0]         b_rs2;

    // Writeback seen on the previous cycle. The registered read issued in
    // that cycle returned the pre-write value, so this covers the gap.
    logic                  lw_valid;
    logic [AW-1:0]         lw_addr;
    logic [DATA_WIDTH-1:0] lw_data;

    logic                  b_free;
    logic                  a_move;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic                  hold_upd1;
    logic                  hold_upd2;

    assign b_free   = !out_valid || out_ready;
    assign a_move   = a_valid && b_free;
    assign in_ready = !a_valid || b_free;
    assign accept   = in_valid && in_ready;

    // A stalled slot A re-reads its own sources so rf data stays current.
    assign rf_rs1_addr = in_ready ? in_rs1 : a_rs1;
    assign rf_rs2_addr = in_ready ? in_rs2 : a_rs2;

    // Operand resolution for slot A: x0, live writeback, last writeback, rf.
    always_comb begin
        op1 = rf_rs1_data;
        if (a_rs1 == '0) begin
            op1 = '0;
        end else if (wb_wren && (wb_addr == a_rs1)) begin
            op1 = wb_data;
        end else if (lw_valid && (lw_addr == a_rs1)) begin
            op1 = lw_data;
        end
    end

    always_comb begin
        op2 = rf_rs2_data;
        if (a_rs2 == '0) begin
            op2 = '0;
        end else if (wb_wren && (wb_addr == a_rs2)) begin
            op2 = wb_data;
        end else if (lw_valid && (lw_addr == a_rs2)) begin
            op2 = lw_data;
        end
    end

    // A held output must track writes to its sources so it is never stale.
    assign hold_upd1 = wb_wren && (wb_addr == b_rs1) && (b_rs1 != '0);
    assign hold_upd2 = wb_wren && (wb_addr == b_rs2) && (b_rs2 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid     <= 1'b0;
            a_rs1       <= '0;
            a_rs2       <= '0;
            a_rd        <= '0;
            a_tag       <= '0;
            b_rs1       <= '0;
            b_rs2       <= '0;
            lw_valid    <= 1'b0;
            lw_addr     <= '0;
            lw_data     <= '0;
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_tag     <= '0;
        end else begin
            lw_valid <= wb_wren;
            lw_addr  <= wb_addr;
            lw_data  <= wb_data;

            if (flush) begin
                // Both slots die; an input accepted this cycle is dropped too.
                a_valid   <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (a_move) begin
                    out_valid   <= 1'b1;
                    out_rs1_val <= op1;
                    out_rs2_val <= op2;
                    out_rd      <= a_rd;
                    out_tag     <= a_tag;
                    b_rs1       <= a_rs1;
                    b_rs2       <= a_rs2;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end else if (out_valid) begin
                    if (hold_upd1) begin
                        out_rs1_val <= wb_data;
                    end
                    if (hold_upd2) begin
                        out_rs2_val <= wb_data;
                    end
                end

                if (accept) begin
                    a_valid <= 1'b1;
                    a_rs1   <= in_rs1;
                    a_rs2   <= in_rs2;
                    a_rd    <= in_rd;
                    a_tag   <= in_tag;
                end else if (a_move) begin
                    a_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int TW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [TW-1:0] in_tag;
    logic [AW-1:0] rf_rs1_addr, rf_rs2_addr;
    logic [DW-1:0] rf_rs1_data, rf_rs2_data;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_wren;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rs1_val, out_rs2_val;
    logic [AW-1:0] out_rd;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    operand_fetch #(
        .DATA_WIDTH (DW),
        .REG_NUM    (RN),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_tag      (in_tag),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs2_data (rf_rs2_data),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_wren     (wb_wren),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd),
        .out_tag     (out_tag)
    );

    // Register-file model: registered read, read-before-write on the same edge.
    logic [DW-1:0] regs [RN];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RN; i++) regs[i] <= '0;
        end else if (wb_wren && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
        rf_rs1_data <= regs[rf_rs1_addr];
        rf_rs2_data <= regs[rf_rs2_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [AW-1:0] rd;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [TW-1:0] tag;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    exp_t sbq[$];
    int   pop_cyc[$];
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every output transfer against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got tag %0h, required no output", out_tag);
            end else begin
                e = sbq.pop_front();
                check("out_rs1_val", 64'(out_rs1_val), 64'(e.v1));
                check("out_rs2_val", 64'(out_rs2_val), 64'(e.v2));
                check("out_rd", 64'(out_rd), 64'(e.rd));
                check("out_tag", 64'(out_tag), 64'(e.tag));
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_wren = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_wren = 1'b0;
    endtask

    // Present one instruction, wait (bounded) for acceptance, push expectation.
    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [TW-1:0] tag,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input bit chk_rdy);
        exp_t e;
        int   k;
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_tag   = tag;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (chk_rdy && k == 0) check("stream_in_ready", 64'(in_ready), 64'(1));
            if (in_ready) break;
            tick();
        end
        if (k == 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready 0 for tag %0h, required 1", tag);
        end else if (!flush) begin
            e.v1  = e1;
            e.v2  = e2;
            e.rd  = rd;
            e.tag = tag;
            sbq.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p0;
        vecs[0] = '{5'd1, 5'd2, 5'd10, 8'h40, 32'h1111, 32'h2222};
        vecs[1] = '{5'd5, 5'd0, 5'd11, 8'h41, 32'h1234, 32'h0};
        vecs[2] = '{5'd0, 5'd3, 5'd12, 8'h42, 32'h0,    32'hCAFE};
        vecs[3] = '{5'd7, 5'd8, 5'd13, 8'h43, 32'hBBBB, 32'hCCCC};
        vecs[4] = '{5'd3, 5'd3, 5'd14, 8'h44, 32'hCAFE, 32'hCAFE};
        vecs[5] = '{5'd9, 5'd1, 5'd15, 8'h45, 32'h0,    32'h1111};
        vecs[6] = '{5'd8, 5'd7, 5'd16, 8'h46, 32'hCCCC, 32'hBBBB};
        vecs[7] = '{5'd2, 5'd5, 5'd17, 8'h47, 32'h2222, 32'h1234};
        vecs[8] = '{5'd0, 5'd0, 5'd18, 8'h48, 32'h0,    32'h0};
        vecs[9] = '{5'd1, 5'd7, 5'd19, 8'h49, 32'h1111, 32'hBBBB};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_tag    = '0;
        wb_addr   = '0;
        wb_data   = '0;
        wb_wren   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        tick();
        tick();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_rs1_val", 64'(out_rs1_val), 64'(0));
        check("rst_out_rs2_val", 64'(out_rs2_val), 64'(0));
        check("rst_out_rd", 64'(out_rd), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        tick();
        rst = 1'b0;

        wb(5'd1, 32'h1111);
        wb(5'd2, 32'h2222);
        wb(5'd3, 32'h3333);
        wb(5'd5, 32'h1234);
        wb(5'd7, 32'h7777);
        wb(5'd8, 32'h8888);
        tick();
        tick();

        // Basic read with x0 operand and latency
        issue(5'd5, 5'd0, 5'd1, 8'h11, 32'h1234, 32'h0, 1'b0);
        @(negedge clk);
        check("lat_n1_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_n2_out_valid", 64'(out_valid), 64'(1));
        tick();
        tick();

        // Live writeback wins over last-write and rf data
        wb_wren = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'hAAAA;
        issue(5'd7, 5'd5, 5'd2, 8'h22, 32'hBBBB, 32'h1234, 1'b0);
        wb_data = 32'hBBBB;
        tick();
        wb_wren = 1'b0;
        tick();
        tick();
        tick();

        // Last-write bypass covers a write in the accept cycle
        wb_wren = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'hCCCC;
        issue(5'd8, 5'd8, 5'd3, 8'h23, 32'hCCCC, 32'hCCCC, 1'b0);
        wb_wren = 1'b0;
        tick();
        tick();
        tick();

        // Backpressure with held-operand bypass
        out_ready = 1'b0;
        issue(5'd5, 5'd3, 5'd4, 8'h31, 32'h1234, 32'hCAFE, 1'b0);
        issue(5'd3, 5'd0, 5'd5, 8'h32, 32'hCAFE, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                wb_wren = 1'b1;
                wb_addr = 5'd3;
                wb_data = 32'hCAFE;
            end
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            tick();
            wb_wren = 1'b0;
        end
        @(negedge clk);
        check("held_rs2_bypass", 64'(out_rs2_val), 64'(32'hCAFE));
        check("held_rs1_kept", 64'(out_rs1_val), 64'(32'h1234));
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Table-driven back-to-back stream
        p0 = pop_cyc.size();
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].tag,
                  vecs[i].e1, vecs[i].e2, 1'b1);
        end
        for (int k = 0; k < 10 && (pop_cyc.size() - p0) < 10; k++) tick();
        check("stream_count", 64'(pop_cyc.size() - p0), 64'(10));
        if (pop_cyc.size() - p0 >= 10)
            check("stream_span", 64'(pop_cyc[p0 + 9] - pop_cyc[p0]), 64'(9));
        tick();

        // Flush with both slots full and an input accepted in the flush cycle
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd6, 8'h51, 32'h1111, 32'h2222, 1'b0);
        issue(5'd2, 5'd1, 5'd7, 8'h52, 32'h2222, 32'h1111, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rs1    = 5'd5;
        in_rs2    = 5'd5;
        in_rd     = 5'd8;
        in_tag    = 8'h53;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_cycle_in_ready", 64'(in_ready), 64'(1));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("flush_out_valid_n1", 64'(out_valid), 64'(0));
        tick();
        @(negedge clk);
        check("flush_out_valid_n2", 64'(out_valid), 64'(0));
        tick();
        issue(5'd5, 5'd1, 5'd9, 8'h54, 32'h1234, 32'h1111, 1'b0);
        tick();
        tick();
        tick();
        check("flush_drain_empty", 64'(sbq.size()), 64'(0));

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd10, 8'h61, 32'h1111, 32'h2222, 1'b0);
        issue(5'd2, 5'd1, 5'd11, 8'h62, 32'h2222, 32'h1111, 1'b0);
        tick();
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        check("pre_rst_in_ready", 64'(in_ready), 64'(0));
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_out_rs1_val", 64'(out_rs1_val), 64'(0));
        check("async_rst_out_tag", 64'(out_tag), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        sbq.delete();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
